mips_decode_execute: RTL and testbench

- Combined instruction decoder, ALU-control decoder, ALU and HI/LO register pair for the single-cycle Harvard MIPS-I CPU.
- Takes the current instruction word and the two register-file read values.
- Produces all datapath control selects, the ALU result, the branch decision and the memory byte enables.
- Holds the HI/LO registers that MULT/DIV/MTHI/MTLO update.

---
 rtl/mips_decode_execute.sv | 333 +++++++++++++++++++++++++++++++++
 tb/tb_mips_decode_execute.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_decode_execute.sv
// mips_decode_execute
// Decode, ALU, branch compare and HI/LO register pair for a single-cycle
// Harvard MIPS-I core. Everything except HI/LO is combinational from the
// current instruction and the two register-file read values.
//
// Ports
//   clk, reset        clock and synchronous active-high reset
//   clk_enable        execution enable; gates HI/LO updates and all strobes
//   active            CPU running flag; gates all strobes
//   instr             current instruction word
//   reg_a, reg_b      rs / rt read data
//   alu_result        ALU output, also the data address
//   branch_true       conditional branch taken
//   pc_sel            00 PC+4, 01 branch, 10 J/JAL target, 11 rs
//   reg_write_enable  GPR write strobe
//   reg_addr_sel      00 rt, 01 rd, 1x $31
//   reg_data_sel      00 ALU, 01 read data, 10 extended load, 11 link PC
//   lwlr_sel          bit1 LWL/LWR merge path, bit0 set for LWL
//   signextend_sel    1 sign-extend, 0 zero-extend
//   data_read/write   memory strobes
//   byte_enable       memory byte lanes
//   byte_offset       alu_result[1:0]
//   hi, lo            HI/LO registers
module mips_decode_execute (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        active,
  input  logic [31:0] instr,
  input  logic [31:0] reg_a,
  input  logic [31:0] reg_b,
  output logic [31:0] alu_result,
  output logic        branch_true,
  output logic [1:0]  pc_sel,
  output logic        reg_write_enable,
  output logic [1:0]  reg_addr_sel,
  output logic [1:0]  reg_data_sel,
  output logic [1:0]  lwlr_sel,
  output logic        signextend_sel,
  output logic        data_read,
  output logic        data_write,
  output logic [3:0]  byte_enable,
  output logic [1:0]  byte_offset,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02,
                         OP_JAL     = 6'h03, OP_BEQ    = 6'h04, OP_BNE   = 6'h05,
                         OP_BLEZ    = 6'h06, OP_BGTZ   = 6'h07, OP_ADDIU = 6'h09,
                         OP_SLTI    = 6'h0A, OP_SLTIU  = 6'h0B, OP_ANDI  = 6'h0C,
                         OP_ORI     = 6'h0D, OP_XORI   = 6'h0E, OP_LUI   = 6'h0F,
                         OP_LB      = 6'h20, OP_LH     = 6'h21, OP_LWL   = 6'h22,
                         OP_LW      = 6'h23, OP_LBU    = 6'h24, OP_LHU   = 6'h25,
                         OP_LWR     = 6'h26, OP_SB     = 6'h28, OP_SH    = 6'h29,
                         OP_SW      = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL   = 6'h02, FN_SRA  = 6'h03,
                         FN_SLLV = 6'h04, FN_SRLV  = 6'h06, FN_SRAV = 6'h07,
                         FN_JR   = 6'h08, FN_JALR  = 6'h09, FN_MFHI = 6'h10,
                         FN_MTHI = 6'h11, FN_MFLO  = 6'h12, FN_MTLO = 6'h13,
                         FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV  = 6'h1A,
                         FN_DIVU = 6'h1B, FN_ADDU  = 6'h21, FN_SUBU = 6'h23,
                         FN_AND  = 6'h24, FN_OR    = 6'h25, FN_XOR  = 6'h26,
                         FN_NOR  = 6'h27, FN_SLT   = 6'h2A, FN_SLTU = 6'h2B;

  localparam logic [4:0] RI_BLTZ = 5'h00, RI_BGEZ = 5'h01,
                         RI_BLTZAL = 5'h10, RI_BGEZAL = 5'h11;

  typedef enum logic [3:0] {
    ALU_NONE, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT,
    ALU_SLTU, ALU_LUI, ALU_SLL, ALU_SRL, ALU_SRA, ALU_MFHI, ALU_MFLO
  } alu_op_t;

  typedef enum logic [2:0] {
    BR_NONE, BR_EQ, BR_NE, BR_LEZ, BR_GTZ, BR_LTZ, BR_GEZ
  } br_op_t;

  typedef enum logic [2:0] {
    HL_NONE, HL_MULT, HL_MULTU, HL_DIV, HL_DIVU, HL_MTHI, HL_MTLO
  } hl_op_t;

  typedef enum logic [1:0] {MEM_NONE, MEM_BYTE, MEM_HALF, MEM_WORD} mem_size_t;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rt_field;
  logic [15:0] imm;
  logic        unused_rs;

  assign opcode    = instr[31:26];
  assign funct     = instr[5:0];
  assign rt_field  = instr[20:16];
  assign imm       = instr[15:0];
  // rs is only ever consumed through reg_a.
  assign unused_rs = ^instr[25:21];

  alu_op_t   alu_op;
  br_op_t    br_op;
  hl_op_t    hl_op;
  mem_size_t mem_size;
  logic      use_imm, zext_imm, shift_var, is_load, is_store, writes_reg;

  always_comb begin
    alu_op         = ALU_NONE;
    br_op          = BR_NONE;
    hl_op          = HL_NONE;
    mem_size       = MEM_NONE;
    use_imm        = 1'b0;
    zext_imm       = 1'b0;
    shift_var      = 1'b0;
    is_load        = 1'b0;
    is_store       = 1'b0;
    writes_reg     = 1'b0;
    reg_addr_sel   = 2'b00;
    reg_data_sel   = 2'b00;
    lwlr_sel       = 2'b00;
    signextend_sel = 1'b1;
    pc_sel         = 2'b00;

    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          FN_SLL:   begin alu_op = ALU_SLL;  writes_reg = 1'b1; reg_addr_sel = 2'b01; end
          FN_SRL:   begin alu_op = ALU_SRL;  writes_reg = 1'b1; reg_addr_sel = 2'b01; end
          FN_SRA:   begin alu_op = ALU_SRA;  writes_reg = 1'b1; reg_addr_sel = 2'b01; end
          FN_SLLV:  begin alu_op = ALU_SLL;  shift_var = 1'b1; writes_reg = 1'b1; reg_addr_sel = 2'b01; end
          FN_SRLV:  begin alu_op = ALU_SRL;  shift_var = 1'b1; writes_reg = 1'b1; reg_addr_sel = 2'b01; end
          FN_SRAV:  begin alu_op = ALU_SRA;  shift_var = 1'b1; writes_reg = 1'b1; reg_addr_sel = 2'b01; end
          FN_JR:    pc_sel = 2'b11;
          FN_JALR:  begin
            pc_sel       = 2'b11;
            writes_reg   = 1'b1;
            reg_addr_sel = 2'b01;
            reg_data_sel = 2'b11;
          end
          FN_MFHI:  begin alu_op = ALU_MFHI; writes_reg = 1'b1; reg_addr_sel = 2'b01; end
          FN_MFLO:  begin alu_op = ALU_MFLO; writes_reg = 1'b1; reg_addr_sel = 2'b01; end
          FN_MTHI:  hl_op = HL_MTHI;
          FN_MTLO:  hl_op = HL_MTLO;
          FN_MULT:  hl_op = HL_MULT;
          FN_MULTU: hl_op = HL_MULTU;
          FN_DIV:   hl_op = HL_DIV;
          FN_DIVU:  hl_op = HL_DIVU;
          FN_ADDU:  begin alu_op = ALU_ADD;  writes_reg = 1'b1; reg_addr_sel = 2'b01; end
          FN_SUBU:  begin alu_op = ALU_SUB;  writes_reg = 1'b1; reg_addr_sel = 2'b01; end
          FN_AND:   begin alu_op = ALU_AND;  writes_reg = 1'b1; reg_addr_sel = 2'b01; end
          FN_OR:    begin alu_op = ALU_OR;   writes_reg = 1'b1; reg_addr_sel = 2'b01; end
          FN_XOR:   begin alu_op = ALU_XOR;  writes_reg = 1'b1; reg_addr_sel = 2'b01; end
          FN_NOR:   begin alu_op = ALU_NOR;  writes_reg = 1'b1; reg_addr_sel = 2'b01; end
          FN_SLT:   begin alu_op = ALU_SLT;  writes_reg = 1'b1; reg_addr_sel = 2'b01; end
          FN_SLTU:  begin alu_op = ALU_SLTU; writes_reg = 1'b1; reg_addr_sel = 2'b01; end
          default: ;
        endcase
      end
      OP_REGIMM: begin
        case (rt_field)
          RI_BLTZ: begin br_op = BR_LTZ; pc_sel = 2'b01; end
          RI_BGEZ: begin br_op = BR_GEZ; pc_sel = 2'b01; end
          // Linking branches write $31 whether or not the branch is taken.
          RI_BLTZAL: begin
            br_op        = BR_LTZ;
            pc_sel       = 2'b01;
            writes_reg   = 1'b1;
            reg_addr_sel = 2'b10;
            reg_data_sel = 2'b11;
          end
          RI_BGEZAL: begin
            br_op        = BR_GEZ;
            pc_sel       = 2'b01;
            writes_reg   = 1'b1;
            reg_addr_sel = 2'b10;
            reg_data_sel = 2'b11;
          end
          default: ;
        endcase
      end
      OP_J:    pc_sel = 2'b10;
      OP_JAL:  begin
        pc_sel       = 2'b10;
        writes_reg   = 1'b1;
        reg_addr_sel = 2'b10;
        reg_data_sel = 2'b11;
      end
      OP_BEQ:  begin br_op = BR_EQ;  pc_sel = 2'b01; end
      OP_BNE:  begin br_op = BR_NE;  pc_sel = 2'b01; end
      OP_BLEZ: begin br_op = BR_LEZ; pc_sel = 2'b01; end
      OP_BGTZ: begin br_op = BR_GTZ; pc_sel = 2'b01; end
      OP_ADDIU: begin alu_op = ALU_ADD;  use_imm = 1'b1; writes_reg = 1'b1; end
      OP_SLTI:  begin alu_op = ALU_SLT;  use_imm = 1'b1; writes_reg = 1'b1; end
      OP_SLTIU: begin alu_op = ALU_SLTU; use_imm = 1'b1; writes_reg = 1'b1; end
      OP_ANDI: begin
        alu_op = ALU_AND; use_imm = 1'b1; zext_imm = 1'b1;
        signextend_sel = 1'b0; writes_reg = 1'b1;
      end
      OP_ORI: begin
        alu_op = ALU_OR; use_imm = 1'b1; zext_imm = 1'b1;
        signextend_sel = 1'b0; writes_reg = 1'b1;
      end
      OP_XORI: begin
        alu_op = ALU_XOR; use_imm = 1'b1; zext_imm = 1'b1;
        signextend_sel = 1'b0; writes_reg = 1'b1;
      end
      OP_LUI: begin alu_op = ALU_LUI; writes_reg = 1'b1; end
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR: begin
        alu_op     = ALU_ADD;
        use_imm    = 1'b1;
        is_load    = 1'b1;
        writes_reg = 1'b1;
        case (opcode)
          OP_LB:   begin mem_size = MEM_BYTE; reg_data_sel = 2'b10; end
          OP_LBU:  begin mem_size = MEM_BYTE; reg_data_sel = 2'b10; signextend_sel = 1'b0; end
          OP_LH:   begin mem_size = MEM_HALF; reg_data_sel = 2'b10; end
          OP_LHU:  begin mem_size = MEM_HALF; reg_data_sel = 2'b10; signextend_sel = 1'b0; end
          OP_LWL:  begin mem_size = MEM_WORD; reg_data_sel = 2'b01; lwlr_sel = 2'b11; end
          OP_LWR:  begin mem_size = MEM_WORD; reg_data_sel = 2'b01; lwlr_sel = 2'b10; end
          default: begin mem_size = MEM_WORD; reg_data_sel = 2'b01; end
        endcase
      end
      OP_SB: begin alu_op = ALU_ADD; use_imm = 1'b1; is_store = 1'b1; mem_size = MEM_BYTE; end
      OP_SH: begin alu_op = ALU_ADD; use_imm = 1'b1; is_store = 1'b1; mem_size = MEM_HALF; end
      OP_SW: begin alu_op = ALU_ADD; use_imm = 1'b1; is_store = 1'b1; mem_size = MEM_WORD; end
      default: ;
    endcase
  end

  logic [31:0] imm_ext;
  logic [31:0] op_b;
  logic [4:0]  shamt;

  assign imm_ext = zext_imm ? {16'h0000, imm} : {{16{imm[15]}}, imm};
  assign op_b    = use_imm ? imm_ext : reg_b;
  assign shamt   = shift_var ? reg_a[4:0] : instr[10:6];

  always_comb begin
    alu_result = 32'h0;
    case (alu_op)
      ALU_ADD:  alu_result = reg_a + op_b;
      ALU_SUB:  alu_result = reg_a - op_b;
      ALU_AND:  alu_result = reg_a & op_b;
      ALU_OR:   alu_result = reg_a | op_b;
      ALU_XOR:  alu_result = reg_a ^ op_b;
      ALU_NOR:  alu_result = ~(reg_a | op_b);
      ALU_SLT:  alu_result = {31'h0, $signed(reg_a) < $signed(op_b)};
      ALU_SLTU: alu_result = {31'h0, reg_a < op_b};
      ALU_LUI:  alu_result = {imm, 16'h0000};
      ALU_SLL:  alu_result = reg_b << shamt;
      ALU_SRL:  alu_result = reg_b >> shamt;
      ALU_SRA:  alu_result = $signed(reg_b) >>> shamt;
      ALU_MFHI: alu_result = hi;
      ALU_MFLO: alu_result = lo;
      default:  alu_result = 32'h0;
    endcase
  end

  assign byte_offset = alu_result[1:0];

  logic a_neg, a_zero;
  assign a_neg  = reg_a[31];
  assign a_zero = (reg_a == 32'h0);

  always_comb begin
    branch_true = 1'b0;
    case (br_op)
      BR_EQ:   branch_true = (reg_a == reg_b);
      BR_NE:   branch_true = (reg_a != reg_b);
      BR_LEZ:  branch_true = a_neg | a_zero;
      BR_GTZ:  branch_true = ~a_neg & ~a_zero;
      BR_LTZ:  branch_true = a_neg;
      BR_GEZ:  branch_true = ~a_neg;
      default: branch_true = 1'b0;
    endcase
  end

  always_comb begin
    byte_enable = 4'b0000;
    case (mem_size)
      MEM_BYTE: byte_enable = 4'b0001 << alu_result[1:0];
      MEM_HALF: byte_enable = alu_result[1] ? 4'b1100 : 4'b0011;
      MEM_WORD: byte_enable = 4'b1111;
      default:  byte_enable = 4'b0000;
    endcase
  end

  logic strobe_en;
  assign strobe_en        = ~reset & clk_enable & active;
  assign reg_write_enable = writes_reg & strobe_en;
  assign data_read        = is_load & strobe_en;
  assign data_write       = is_store & strobe_en;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  assign prod_s = $signed(reg_a) * $signed(reg_b);
  assign prod_u = {32'h0, reg_a} * {32'h0, reg_b};

  // DIV and DIVU share one unsigned divider: signed operands are converted
  // to magnitudes, then the quotient takes the XOR of the signs and the
  // remainder takes the dividend's sign (truncation toward zero).
  logic        signed_div, neg_a, neg_b;
  logic [31:0] mag_a, mag_b, q_mag, r_mag, quotient, remainder;

  assign signed_div = (hl_op == HL_DIV);
  assign neg_a      = signed_div & reg_a[31];
  assign neg_b      = signed_div & reg_b[31];
  assign mag_a      = neg_a ? (~reg_a + 32'd1) : reg_a;
  assign mag_b      = neg_b ? (~reg_b + 32'd1) : reg_b;
  assign q_mag      = mag_a / mag_b;
  assign r_mag      = mag_a % mag_b;
  assign quotient   = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
  assign remainder  = neg_a ? (~r_mag + 32'd1) : r_mag;

  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= 32'h0;
      lo <= 32'h0;
    end else if (strobe_en) begin
      case (hl_op)
        HL_MULT:  {hi, lo} <= prod_s;
        HL_MULTU: {hi, lo} <= prod_u;
        HL_DIV, HL_DIVU: begin
          if (reg_b != 32'h0) begin
            lo <= quotient;
            hi <= remainder;
          end
        end
        HL_MTHI:  hi <= reg_a;
        HL_MTLO:  lo <= reg_a;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_decode_execute.sv
module tb_mips_decode_execute;

  logic        clk = 1'b0;
  logic        reset, clk_enable, active;
  logic [31:0] instr, reg_a, reg_b;
  logic [31:0] alu_result, hi, lo;
  logic        branch_true, reg_write_enable, signextend_sel, data_read, data_write;
  logic [1:0]  pc_sel, reg_addr_sel, reg_data_sel, lwlr_sel, byte_offset;
  logic [3:0]  byte_enable;

  mips_decode_execute dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .active(active),
    .instr(instr), .reg_a(reg_a), .reg_b(reg_b),
    .alu_result(alu_result), .branch_true(branch_true), .pc_sel(pc_sel),
    .reg_write_enable(reg_write_enable), .reg_addr_sel(reg_addr_sel),
    .reg_data_sel(reg_data_sel), .lwlr_sel(lwlr_sel),
    .signextend_sel(signextend_sel), .data_read(data_read),
    .data_write(data_write), .byte_enable(byte_enable),
    .byte_offset(byte_offset), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef enum int {
    M_ADDU, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU,
    M_SLL, M_SRL, M_SRA, M_SLLV, M_SRLV, M_SRAV, M_JR, M_JALR,
    M_MFHI, M_MTHI, M_MFLO, M_MTLO, M_MULT, M_MULTU, M_DIV, M_DIVU,
    M_BLTZ, M_BGEZ, M_BLTZAL, M_BGEZAL, M_J, M_JAL, M_BEQ, M_BNE,
    M_BLEZ, M_BGTZ, M_ADDIU, M_SLTI, M_SLTIU, M_ANDI, M_ORI, M_XORI,
    M_LUI, M_LB, M_LH, M_LWL, M_LW, M_LBU, M_LHU, M_LWR,
    M_SB, M_SH, M_SW, M_UNDEF
  } mn_t;

  typedef struct {
    mn_t         m;
    logic [31:0] alu;
    bit          alu_chk;
    bit          br;
    logic [1:0]  pc;
    bit          wi;
    logic [1:0]  ras, rds, lwlr;
    bit          sx, we, rd, wr;
    logic [3:0]  be;
    logic [31:0] hi, lo;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mh, ml;

  // Assemble a machine word for a mnemonic; register fields are random
  // because the operands arrive separately on reg_a/reg_b.
  function automatic logic [31:0] enc(mn_t m, logic [15:0] imm, logic [4:0] sh);
    logic [4:0] rs, rt, rd;
    logic [5:0] code;
    int         kind;
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
    kind = 0; code = 6'h00;
    case (m)
      M_SLL: code = 6'h00;  M_SRL: code = 6'h02;  M_SRA: code = 6'h03;
      M_SLLV: code = 6'h04; M_SRLV: code = 6'h06; M_SRAV: code = 6'h07;
      M_JR: code = 6'h08;   M_JALR: code = 6'h09; M_MFHI: code = 6'h10;
      M_MTHI: code = 6'h11; M_MFLO: code = 6'h12; M_MTLO: code = 6'h13;
      M_MULT: code = 6'h18; M_MULTU: code = 6'h19; M_DIV: code = 6'h1A;
      M_DIVU: code = 6'h1B; M_ADDU: code = 6'h21; M_SUBU: code = 6'h23;
      M_AND: code = 6'h24;  M_OR: code = 6'h25;   M_XOR: code = 6'h26;
      M_NOR: code = 6'h27;  M_SLT: code = 6'h2A;  M_SLTU: code = 6'h2B;
      M_BLTZ: begin kind = 2; code = 6'h00; end
      M_BGEZ: begin kind = 2; code = 6'h01; end
      M_BLTZAL: begin kind = 2; code = 6'h10; end
      M_BGEZAL: begin kind = 2; code = 6'h11; end
      M_J:   begin kind = 3; code = 6'h02; end
      M_JAL: begin kind = 3; code = 6'h03; end
      M_BEQ: begin kind = 1; code = 6'h04; end
      M_BNE: begin kind = 1; code = 6'h05; end
      M_BLEZ: begin kind = 1; code = 6'h06; end
      M_BGTZ: begin kind = 1; code = 6'h07; end
      M_ADDIU: begin kind = 1; code = 6'h09; end
      M_SLTI: begin kind = 1; code = 6'h0A; end
      M_SLTIU: begin kind = 1; code = 6'h0B; end
      M_ANDI: begin kind = 1; code = 6'h0C; end
      M_ORI: begin kind = 1; code = 6'h0D; end
      M_XORI: begin kind = 1; code = 6'h0E; end
      M_LUI: begin kind = 1; code = 6'h0F; end
      M_LB: begin kind = 1; code = 6'h20; end
      M_LH: begin kind = 1; code = 6'h21; end
      M_LWL: begin kind = 1; code = 6'h22; end
      M_LW: begin kind = 1; code = 6'h23; end
      M_LBU: begin kind = 1; code = 6'h24; end
      M_LHU: begin kind = 1; code = 6'h25; end
      M_LWR: begin kind = 1; code = 6'h26; end
      M_SB: begin kind = 1; code = 6'h28; end
      M_SH: begin kind = 1; code = 6'h29; end
      M_SW: begin kind = 1; code = 6'h2B; end
      default: begin
        case ($urandom_range(0, 3))
          0: begin kind = 1; code = 6'h3F; end
          1: begin kind = 0; code = 6'h01; end
          2: begin kind = 0; code = 6'h3F; end
          default: begin kind = 2; code = 6'h05; end
        endcase
      end
    endcase
    case (kind)
      0: return {6'h00, rs, rt, rd, sh, code};
      1: return {code, rs, rt, imm};
      2: return {6'h01, rs, code[4:0], imm};
      default: return {code, 26'($urandom)};
    endcase
  endfunction

  // Reference behaviour per mnemonic, straight from the instruction set rules.
  function automatic exp_t model(mn_t m, logic [31:0] a, logic [31:0] b, logic [15:0] imm,
                                 logic [4:0] sh, logic [31:0] h, logic [31:0] l, bit g);
    exp_t e;
    logic [31:0] simm, zimm, ea;
    bit rtyp, ityp, ld, st;
    int sz;
    e.m = m; e.alu = 32'h0; e.alu_chk = 0; e.br = 0; e.pc = 2'b00; e.wi = 0;
    e.ras = 2'b00; e.rds = 2'b00; e.lwlr = 2'b00; e.sx = 1; e.hi = h; e.lo = l;
    rtyp = 0; ityp = 0; ld = 0; st = 0; sz = 0;
    simm = {{16{imm[15]}}, imm};
    zimm = {16'h0000, imm};
    ea   = a + simm;
    case (m)
      M_ADDU: begin e.alu = a + b; rtyp = 1; end
      M_SUBU: begin e.alu = a - b; rtyp = 1; end
      M_AND:  begin e.alu = a & b; rtyp = 1; end
      M_OR:   begin e.alu = a | b; rtyp = 1; end
      M_XOR:  begin e.alu = a ^ b; rtyp = 1; end
      M_NOR:  begin e.alu = ~(a | b); rtyp = 1; end
      M_SLT:  begin e.alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; rtyp = 1; end
      M_SLTU: begin e.alu = (a < b) ? 32'd1 : 32'd0; rtyp = 1; end
      M_SLL:  begin e.alu = b << sh; rtyp = 1; end
      M_SRL:  begin e.alu = b >> sh; rtyp = 1; end
      M_SRA:  begin e.alu = $signed(b) >>> sh; rtyp = 1; end
      M_SLLV: begin e.alu = b << a[4:0]; rtyp = 1; end
      M_SRLV: begin e.alu = b >> a[4:0]; rtyp = 1; end
      M_SRAV: begin e.alu = $signed(b) >>> a[4:0]; rtyp = 1; end
      M_MFHI: begin e.alu = h; rtyp = 1; end
      M_MFLO: begin e.alu = l; rtyp = 1; end
      M_JR:   e.pc = 2'b11;
      M_JALR: begin e.pc = 2'b11; e.wi = 1; e.ras = 2'b01; e.rds = 2'b11; end
      M_BLTZ: begin e.pc = 2'b01; e.br = $signed(a) < 0; end
      M_BGEZ: begin e.pc = 2'b01; e.br = $signed(a) >= 0; end
      M_BLTZAL: begin e.pc = 2'b01; e.br = $signed(a) < 0; e.wi = 1; e.ras = 2'b10; e.rds = 2'b11; end
      M_BGEZAL: begin e.pc = 2'b01; e.br = $signed(a) >= 0; e.wi = 1; e.ras = 2'b10; e.rds = 2'b11; end
      M_J:    e.pc = 2'b10;
      M_JAL:  begin e.pc = 2'b10; e.wi = 1; e.ras = 2'b10; e.rds = 2'b11; end
      M_BEQ:  begin e.pc = 2'b01; e.br = (a == b); end
      M_BNE:  begin e.pc = 2'b01; e.br = (a != b); end
      M_BLEZ: begin e.pc = 2'b01; e.br = $signed(a) <= 0; end
      M_BGTZ: begin e.pc = 2'b01; e.br = $signed(a) > 0; end
      M_ADDIU: begin e.alu = a + simm; ityp = 1; end
      M_SLTI:  begin e.alu = ($signed(a) < $signed(simm)) ? 32'd1 : 32'd0; ityp = 1; end
      M_SLTIU: begin e.alu = (a < simm) ? 32'd1 : 32'd0; ityp = 1; end
      M_ANDI: begin e.alu = a & zimm; ityp = 1; e.sx = 0; end
      M_ORI:  begin e.alu = a | zimm; ityp = 1; e.sx = 0; end
      M_XORI: begin e.alu = a ^ zimm; ityp = 1; e.sx = 0; end
      M_LUI:  begin e.alu = {imm, 16'h0000}; ityp = 1; end
      M_LB:  begin ld = 1; sz = 1; e.rds = 2'b10; end
      M_LBU: begin ld = 1; sz = 1; e.rds = 2'b10; e.sx = 0; end
      M_LH:  begin ld = 1; sz = 2; e.rds = 2'b10; end
      M_LHU: begin ld = 1; sz = 2; e.rds = 2'b10; e.sx = 0; end
      M_LW:  begin ld = 1; sz = 4; e.rds = 2'b01; end
      M_LWL: begin ld = 1; sz = 4; e.rds = 2'b01; e.lwlr = 2'b11; end
      M_LWR: begin ld = 1; sz = 4; e.rds = 2'b01; e.lwlr = 2'b10; end
      M_SB:  begin st = 1; sz = 1; end
      M_SH:  begin st = 1; sz = 2; end
      M_SW:  begin st = 1; sz = 4; end
      default: ;
    endcase
    if (rtyp) begin e.alu_chk = 1; e.wi = 1; e.ras = 2'b01; end
    if (ityp) begin e.alu_chk = 1; e.wi = 1; e.ras = 2'b00; end
    if (ld || st) begin e.alu = ea; e.alu_chk = 1; end
    if (ld) begin e.wi = 1; e.ras = 2'b00; end
    case (sz)
      1: e.be = 4'b0001 << ea[1:0];
      2: e.be = 4'b0011 << (2 * ea[1]);
      4: e.be = 4'b1111;
      default: e.be = 4'b0000;
    endcase
    e.we = e.wi && g;
    e.rd = ld && g;
    e.wr = st && g;
    return e;
  endfunction

  task automatic issue(mn_t m, logic [31:0] a, logic [31:0] b, logic [15:0] imm,
                       logic [4:0] sh, bit rst, bit ce, bit act);
    bit g;
    longint sa, sb, p;
    longint unsigned ua, ub;
    instr = enc(m, imm, sh);
    reg_a = a; reg_b = b;
    reset = rst; clk_enable = ce; active = act;
    g = !rst && ce && act;
    q.push_back(model(m, a, b, imm, sh, mh, ml, g));
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'(a); ub = longint'(b);
    if (rst) begin
      mh = 32'h0; ml = 32'h0;
    end else if (g) begin
      case (m)
        M_MULT:  begin p = sa * sb; mh = p[63:32]; ml = p[31:0]; end
        M_MULTU: begin p = longint'(ua * ub); mh = p[63:32]; ml = p[31:0]; end
        M_DIV:   if (b != 0) begin p = sa / sb; ml = p[31:0]; p = sa % sb; mh = p[31:0]; end
        M_DIVU:  if (b != 0) begin ml = a / b; mh = a % b; end
        M_MTHI:  mh = a;
        M_MTLO:  ml = a;
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, mn_t m, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%s] actual=%h required=%h", nm, m.name(), act, exp);
    end
  endtask

  // Monitor: every falling edge with a pending expectation is one observation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc_sel", e.m, 32'(pc_sel), 32'(e.pc));
        chk("branch_true", e.m, 32'(branch_true), 32'(e.br));
        chk("lwlr_sel", e.m, 32'(lwlr_sel), 32'(e.lwlr));
        chk("signextend_sel", e.m, 32'(signextend_sel), 32'(e.sx));
        chk("reg_write_enable", e.m, 32'(reg_write_enable), 32'(e.we));
        chk("data_read", e.m, 32'(data_read), 32'(e.rd));
        chk("data_write", e.m, 32'(data_write), 32'(e.wr));
        chk("byte_enable", e.m, 32'(byte_enable), 32'(e.be));
        chk("hi", e.m, hi, e.hi);
        chk("lo", e.m, lo, e.lo);
        if (e.alu_chk) begin
          chk("alu_result", e.m, alu_result, e.alu);
          chk("byte_offset", e.m, 32'(byte_offset), 32'(e.alu[1:0]));
        end
        if (e.wi) begin
          chk("reg_data_sel", e.m, 32'(reg_data_sel), 32'(e.rds));
          if (e.ras[1]) chk("reg_addr_sel_31", e.m, 32'(reg_addr_sel[1]), 32'd1);
          else          chk("reg_addr_sel", e.m, 32'(reg_addr_sel), 32'(e.ras));
        end
      end
    end
  end

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 16));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    logic [31:0] a, b;
    logic [15:0] imm;
    bit rst, ce, act;
    mn_t m;
    reset = 1'b1; clk_enable = 1'b1; active = 1'b1;
    instr = 32'h0; reg_a = 32'h0; reg_b = 32'h0;
    mh = 32'h0; ml = 32'h0;
    repeat (2) @(posedge clk);
    #1;

    issue(M_ADDU,   32'hFFFF_FFFF, 32'd2, 16'h0, 5'd0, 0, 1, 1);
    issue(M_ADDU,   32'hFFFF_FFFF, 32'd2, 16'h0, 5'd0, 0, 0, 1);
    issue(M_SLTI,   32'hFFFF_FFFE, 32'h0, 16'h0001, 5'd0, 0, 1, 1);
    issue(M_SLTIU,  32'hFFFF_FFFE, 32'h0, 16'h0001, 5'd0, 0, 1, 1);
    issue(M_ORI,    32'h1234_0001, 32'h0, 16'h8000, 5'd0, 0, 1, 1);
    issue(M_MULT,   32'hFFFF_FFFD, 32'd7, 16'h0, 5'd0, 0, 1, 1);
    issue(M_DIV,    32'hFFFF_FFF9, 32'd2, 16'h0, 5'd0, 0, 1, 1);
    issue(M_DIVU,   32'h0000_1234, 32'd0, 16'h0, 5'd0, 0, 1, 1);
    issue(M_MTHI,   32'hCAFE_F00D, 32'd0, 16'h0, 5'd0, 0, 1, 0);
    issue(M_SW,     32'h0000_1000, 32'd0, 16'h0004, 5'd0, 1, 1, 1);
    issue(M_BGEZAL, 32'h0, 32'h0, 16'h0010, 5'd0, 0, 1, 1);
    issue(M_BLTZ,   32'h0, 32'h0, 16'h0010, 5'd0, 0, 1, 1);
    issue(M_BNE,    32'd5, 32'd5, 16'h0010, 5'd0, 0, 1, 1);
    issue(M_SB,     32'h0000_1000, 32'h0, 16'h0003, 5'd0, 0, 1, 1);
    issue(M_SH,     32'h0000_1000, 32'h0, 16'h0002, 5'd0, 0, 1, 1);
    issue(M_LWL,    32'h0000_1000, 32'h0, 16'h0001, 5'd0, 0, 1, 1);
    issue(M_MTLO,   32'h1357_9BDF, 32'h0, 16'h0, 5'd0, 0, 1, 1);
    issue(M_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 16'h0, 5'd0, 0, 1, 1);
    issue(M_MFHI,   32'h0, 32'h0, 16'h0, 5'd0, 0, 1, 1);

    for (int i = 0; i < 4000; i++) begin
      m   = mn_t'($urandom_range(0, int'(M_UNDEF)));
      a   = rnd_val();
      b   = ($urandom_range(0, 3) == 0) ? a : rnd_val();
      case ($urandom_range(0, 3))
        0: imm = 16'h8000;
        1: imm = 16'hFFFF;
        default: imm = 16'($urandom);
      endcase
      rst = ($urandom_range(0, 49) == 0);
      ce  = rst || ($urandom_range(0, 9) != 0);
      act = rst || ($urandom_range(0, 9) != 0);
      issue(m, a, b, imm, 5'($urandom), rst, ce, act);
    end
    issue(M_SLL, 32'h0, 32'h0, 16'h0, 5'd0, 0, 1, 1);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
